// File: rtl/game_flow_controller.sv
// Frog game sequencer: start/play/death/pause/over/win flow, lives tracking and timed freezes.
// Outputs are registered and decoded from the next state so they move on the same edge as the state.
module game_flow_controller #(
  parameter int unsigned LIVES_INI   = 3,
  parameter int unsigned DEATH_TICKS = 25000000,
  parameter int unsigned PAUSE_TICKS = 12500000,
  parameter int unsigned MAX_LEVEL   = 9,
  parameter int unsigned CNT_W       = 25
) (
  input  logic       i_Clk,
  input  logic       i_Rst_N,
  input  logic       i_Start,
  input  logic       i_Has_Collided,
  input  logic       i_Level_Up,
  input  logic [3:0] i_Score,
  output logic       o_Game_Active,
  output logic       o_Freeze,
  output logic [1:0] o_Lives,
  output logic       o_Game_Over,
  output logic       o_Win,
  output logic [2:0] o_State
);

  localparam int unsigned SCORE_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_DEATH = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4,
    ST_WIN   = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           lives_q, lives_d;
  logic                 start_q;
  logic                 start_rise;
  logic [SCORE_W-1:0]   score_next;
  logic                 game_active_q, freeze_q, game_over_q, win_q;

  assign start_rise = i_Start & ~start_q;
  // The mover bumps the score in the same cycle it pulses level-up, so compare against score+1.
  assign score_next = SCORE_W'(i_Score) + SCORE_W'(1);

  // Next-state, counter and lives logic; counter defaults to zero so every state entry clears it.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    lives_d = lives_q;
    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          state_d = ST_PLAY;
          lives_d = 2'(LIVES_INI);
        end
      end
      ST_PLAY: begin
        if (i_Has_Collided) begin
          if (lives_q <= 2'd1) begin
            state_d = ST_OVER;
            lives_d = 2'd0;
          end else begin
            state_d = ST_DEATH;
            lives_d = lives_q - 2'd1;
          end
        end else if (i_Level_Up) begin
          if (score_next >= SCORE_W'(MAX_LEVEL)) state_d = ST_WIN;
          else                                   state_d = ST_PAUSE;
        end
      end
      ST_DEATH: begin
        if (cnt_q == CNT_W'(DEATH_TICKS - 1)) state_d = ST_PLAY;
        else                                   cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_PAUSE: begin
        if (cnt_q == CNT_W'(PAUSE_TICKS - 1)) state_d = ST_PLAY;
        else                                   cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_OVER, ST_WIN: begin
        if (start_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Start edge register resets high so a switch held through reset does not launch a game.
  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      lives_q       <= 2'(LIVES_INI);
      start_q       <= 1'b1;
      game_active_q <= 1'b0;
      freeze_q      <= 1'b1;
      game_over_q   <= 1'b0;
      win_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lives_q       <= lives_d;
      start_q       <= i_Start;
      game_active_q <= (state_d == ST_PLAY);
      freeze_q      <= (state_d != ST_PLAY);
      game_over_q   <= (state_d == ST_OVER);
      win_q         <= (state_d == ST_WIN);
    end
  end

  assign o_Game_Active = game_active_q;
  assign o_Freeze      = freeze_q;
  assign o_Lives       = lives_q;
  assign o_Game_Over   = game_over_q;
  assign o_Win         = win_q;
  assign o_State       = state_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: directed scenarios with literal expectations, then random
// stimulus compared every cycle against a behavioural game model.
module tb_game_flow_controller;

  localparam int unsigned LIVES_INI   = 3;
  localparam int unsigned DEATH_TICKS = 4;
  localparam int unsigned PAUSE_TICKS = 3;
  localparam int unsigned MAX_LEVEL   = 9;
  localparam int unsigned CNT_W       = 4;

  logic       i_Clk = 1'b0;
  logic       i_Rst_N = 1'b0;
  logic       i_Start = 1'b1;
  logic       i_Has_Collided = 1'b0;
  logic       i_Level_Up = 1'b0;
  logic [3:0] i_Score = 4'd0;
  logic       o_Game_Active, o_Freeze, o_Game_Over, o_Win;
  logic [1:0] o_Lives;
  logic [2:0] o_State;

  int checks = 0;
  int failures = 0;

  game_flow_controller #(
    .LIVES_INI(LIVES_INI), .DEATH_TICKS(DEATH_TICKS), .PAUSE_TICKS(PAUSE_TICKS),
    .MAX_LEVEL(MAX_LEVEL), .CNT_W(CNT_W)
  ) dut (
    .i_Clk(i_Clk), .i_Rst_N(i_Rst_N), .i_Start(i_Start), .i_Has_Collided(i_Has_Collided),
    .i_Level_Up(i_Level_Up), .i_Score(i_Score), .o_Game_Active(o_Game_Active),
    .o_Freeze(o_Freeze), .o_Lives(o_Lives), .o_Game_Over(o_Game_Over), .o_Win(o_Win),
    .o_State(o_State)
  );

  always #5 i_Clk = ~i_Clk;

  // Model: game mode uses the display codes, a remaining-ticks timer replaces the up-counter.
  int m_mode, m_lives, m_rem;
  logic m_prev_start;
  always @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      m_mode = 0; m_lives = LIVES_INI; m_rem = 0; m_prev_start = 1'b1;
    end else begin
      automatic bit rise = i_Start && !m_prev_start;
      m_prev_start = i_Start;
      case (m_mode)
        0: if (rise) begin m_mode = 1; m_lives = LIVES_INI; end
        1: begin
          if (i_Has_Collided) begin
            if (m_lives <= 1) begin m_mode = 4; m_lives = 0; end
            else begin m_mode = 2; m_lives = m_lives - 1; m_rem = DEATH_TICKS; end
          end else if (i_Level_Up) begin
            if (int'(i_Score) + 1 >= int'(MAX_LEVEL)) m_mode = 5;
            else begin m_mode = 3; m_rem = PAUSE_TICKS; end
          end
        end
        2, 3: begin
          if (m_rem == 1) m_mode = 1;
          else m_rem = m_rem - 1;
        end
        default: if (rise) m_mode = 0;
      endcase
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge i_Clk) begin
    automatic int exp_act = (m_mode == 1) ? 1 : 0;
    automatic int exp_frz = (m_mode != 1) ? 1 : 0;
    automatic int exp_ovr = (m_mode == 4) ? 1 : 0;
    automatic int exp_win = (m_mode == 5) ? 1 : 0;
    checks++;
    if (int'(o_State) != m_mode || int'(o_Lives) != m_lives || int'(o_Game_Active) != exp_act ||
        int'(o_Freeze) != exp_frz || int'(o_Game_Over) != exp_ovr || int'(o_Win) != exp_win) begin
      failures++;
      $display("FAIL model_cmp t=%0t got state=%0d lives=%0d act=%0d frz=%0d over=%0d win=%0d exp state=%0d lives=%0d act=%0d frz=%0d over=%0d win=%0d",
               $time, o_State, o_Lives, o_Game_Active, o_Freeze, o_Game_Over, o_Win,
               m_mode, m_lives, exp_act, exp_frz, exp_ovr, exp_win);
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge i_Clk);
      #2;
    end
  endtask

  task automatic start_edge();
    i_Start = 1'b0; step();
    i_Start = 1'b1; step();
  endtask

  task automatic collide();
    i_Has_Collided = 1'b1; step();
    i_Has_Collided = 1'b0;
  endtask

  task automatic level_up(input logic [3:0] score);
    i_Level_Up = 1'b1; i_Score = score; step();
    i_Level_Up = 1'b0;
  endtask

  initial begin
    // Switch held high through reset must not start a game.
    #13 i_Rst_N = 1'b1;
    step(3);
    chk("rst_state", o_State, 0);
    chk("rst_freeze", o_Freeze, 1);
    chk("rst_lives", o_Lives, 3);
    chk("rst_active", o_Game_Active, 0);

    start_edge();
    chk("start_state", o_State, 1);
    chk("start_active", o_Game_Active, 1);
    chk("start_freeze", o_Freeze, 0);

    collide();
    chk("death1_state", o_State, 2);
    chk("death1_lives", o_Lives, 2);
    chk("death1_active", o_Game_Active, 0);
    step(3);
    chk("death1_hold", o_State, 2);
    step();
    chk("death1_exit", o_State, 1);

    collide();
    chk("death2_lives", o_Lives, 1);
    step(4);
    chk("death2_exit", o_State, 1);
    collide();
    chk("over_state", o_State, 4);
    chk("over_lives", o_Lives, 0);
    chk("over_flag", o_Game_Over, 1);
    start_edge();
    chk("over_to_idle", o_State, 0);
    start_edge();
    chk("restart_state", o_State, 1);
    chk("restart_lives", o_Lives, 3);

    level_up(4'd4);
    chk("pause_state", o_State, 3);
    step(2);
    chk("pause_hold", o_State, 3);
    step();
    chk("pause_exit", o_State, 1);
    level_up(4'd8);
    chk("win_state", o_State, 5);
    chk("win_flag", o_Win, 1);

    start_edge();
    start_edge();
    i_Has_Collided = 1'b1; i_Level_Up = 1'b1; i_Score = 4'd2; step();
    i_Has_Collided = 1'b0; i_Level_Up = 1'b0;
    chk("both_state", o_State, 2);
    chk("both_lives", o_Lives, 2);
    step();
    i_Rst_N = 1'b0;
    #1;
    chk("async_rst_state", o_State, 0);
    chk("async_rst_lives", o_Lives, 3);
    chk("async_rst_freeze", o_Freeze, 1);
    chk("async_rst_active", o_Game_Active, 0);
    #1 i_Rst_N = 1'b1;

    // Random phase: the every-cycle model comparison does the checking.
    for (int c = 0; c < 2500; c++) begin
      step();
      if ($urandom_range(0, 5) == 0) i_Start = ~i_Start;
      i_Has_Collided = ($urandom_range(0, 9) == 0);
      i_Level_Up     = ($urandom_range(0, 7) == 0);
      i_Score        = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) begin
        i_Rst_N = 1'b0;
        #1 i_Rst_N = 1'b1;
      end
    end
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
